// File: rtl/wb_pipe_stage_pkg.sv
// wb_pipe_stage_pkg: shared constants and state encoding for the MEM->WB stage.
//   RstEnable/WriteDisable/ZeroWord/NOPRegAddr : legacy codebase defines
//   wbp_state_e                                : skid-buffer occupancy states
package wb_pipe_stage_pkg;

    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;

    typedef enum logic [1:0] {
        WBP_EMPTY = 2'b00,
        WBP_ONE   = 2'b01,
        WBP_TWO   = 2'b10
    } wbp_state_e;

endpackage

// File: rtl/wb_pipe_entry.sv
// wb_pipe_entry: one NCH-channel writeback payload register set.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   load          : capture d_* next cycle
//   clr           : return to the empty payload (we=0, addr=NOP_ADDR, data=0); wins over load
//   d_we/d_waddr/d_wdata : payload to capture
//   q_we/q_waddr/q_wdata : registered payload
module wb_pipe_entry
    import wb_pipe_stage_pkg::*;
#(
    parameter int unsigned NCH      = 3,
    parameter int unsigned AW       = 5,
    parameter int unsigned DW       = 32,
    parameter int unsigned NOP_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic [NCH-1:0]    d_we,
    input  logic [NCH*AW-1:0] d_waddr,
    input  logic [NCH*DW-1:0] d_wdata,
    output logic [NCH-1:0]    q_we,
    output logic [NCH*AW-1:0] q_waddr,
    output logic [NCH*DW-1:0] q_wdata
);

    logic [NCH-1:0]    we_q,    we_d;
    logic [NCH*AW-1:0] waddr_q, waddr_d;
    logic [NCH*DW-1:0] wdata_q, wdata_d;
    logic [NCH*AW-1:0] nop_waddr;
    logic [NCH*DW-1:0] nop_wdata;

    // Empty-payload image, replicated per channel
    always_comb begin
        nop_waddr = '0;
        nop_wdata = '0;
        for (int k = 0; k < NCH; k++) begin
            nop_waddr[k*AW +: AW] = AW'(NOP_ADDR);
            nop_wdata[k*DW +: DW] = DW'(ZeroWord);
        end
    end

    // Next payload: clear beats load beats hold
    always_comb begin
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (clr) begin
            we_d    = {NCH{WriteDisable}};
            waddr_d = nop_waddr;
            wdata_d = nop_wdata;
        end else if (load) begin
            we_d    = d_we;
            waddr_d = d_waddr;
            wdata_d = d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            we_q    <= {NCH{WriteDisable}};
            waddr_q <= nop_waddr;
            wdata_q <= nop_wdata;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign q_we    = we_q;
    assign q_waddr = waddr_q;
    assign q_wdata = wdata_q;

endmodule

// File: rtl/wb_pipe_stage.sv
// wb_pipe_stage: MEM->WB pipeline register with valid/ready handshake,
// 2-entry skid buffer (main + skid) and synchronous flush.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   flush               : squash all held entries
//   in_valid/in_ready   : mem-side handshake (in_ready is a pure register)
//   in_we/in_waddr/in_wdata    : NCH channels, ch k at [k*W +: W]
//   out_valid/out_ready : wb-side handshake
//   out_we/out_waddr/out_wdata : main-entry payload, empty payload when out_valid=0
//   stall_cnt           : saturating stall counter, only with WBPIPE_STALL_CNT_EN
module wb_pipe_stage
    import wb_pipe_stage_pkg::*;
#(
    parameter int unsigned NCH      = 3,
    parameter int unsigned AW       = 5,
    parameter int unsigned DW       = 32,
    parameter int unsigned NOP_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH-1:0]    in_we,
    input  logic [NCH*AW-1:0] in_waddr,
    input  logic [NCH*DW-1:0] in_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH-1:0]    out_we,
    output logic [NCH*AW-1:0] out_waddr,
    output logic [NCH*DW-1:0] out_wdata
`ifdef WBPIPE_STALL_CNT_EN
    ,output logic [31:0]      stall_cnt
`endif
);

    wbp_state_e state_q, state_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;

    logic in_xfer, out_xfer;
    logic main_load, main_clr, main_from_skid;
    logic skid_load, skid_clr;

    logic [NCH-1:0]    main_d_we,    skid_we;
    logic [NCH*AW-1:0] main_d_waddr, skid_waddr;
    logic [NCH*DW-1:0] main_d_wdata, skid_wdata;

    // Next state and entry control
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        in_xfer        = in_valid & in_ready_q;
        out_xfer       = out_valid_q & out_ready;

        if (flush) begin
            state_d  = WBP_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            unique case (state_q)
                WBP_EMPTY: begin
                    if (in_xfer) begin
                        main_load = 1'b1;
                        state_d   = WBP_ONE;
                    end
                end
                WBP_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (out_xfer) begin
                        main_clr = 1'b1;
                        state_d  = WBP_EMPTY;
                    end else if (in_xfer) begin
                        skid_load = 1'b1;
                        state_d   = WBP_TWO;
                    end
                end
                WBP_TWO: begin
                    // in_ready is low here, so only the drain can happen
                    if (out_xfer) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_d        = WBP_ONE;
                    end
                end
                default: begin
                    state_d  = WBP_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end

        in_ready_d  = (state_d != WBP_TWO);
        out_valid_d = (state_d != WBP_EMPTY);

        main_d_we    = main_from_skid ? skid_we    : in_we;
        main_d_waddr = main_from_skid ? skid_waddr : in_waddr;
        main_d_wdata = main_from_skid ? skid_wdata : in_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q     <= WBP_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Main entry drives the outputs directly
    wb_pipe_entry #(
        .NCH      (NCH),
        .AW       (AW),
        .DW       (DW),
        .NOP_ADDR (NOP_ADDR)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load),
        .clr     (main_clr),
        .d_we    (main_d_we),
        .d_waddr (main_d_waddr),
        .d_wdata (main_d_wdata),
        .q_we    (out_we),
        .q_waddr (out_waddr),
        .q_wdata (out_wdata)
    );

    // Skid entry catches the transfer accepted while wb stalls
    wb_pipe_entry #(
        .NCH      (NCH),
        .AW       (AW),
        .DW       (DW),
        .NOP_ADDR (NOP_ADDR)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clr     (skid_clr),
        .d_we    (in_we),
        .d_waddr (in_waddr),
        .d_wdata (in_wdata),
        .q_we    (skid_we),
        .q_waddr (skid_waddr),
        .q_wdata (skid_wdata)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

`ifdef WBPIPE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles wb holds off a valid entry; flush does not clear it
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
